// File: rtl/axi_arbiter_pkg.sv
// Shared types and constants for the two-master AXI4-Lite arbiter.
package axi_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD0  = 2'd1,
        ST_RD1  = 2'd2,
        ST_WR1  = 2'd3
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_arbiter_rr_arb2.sv
// Two-way round-robin grant; the pointer flips to favour the other master on each accepted grant.
module axi_arbiter_rr_arb2
    import axi_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_accept,
    output logic o_gnt0_c,
    output logic o_gnt1_c
);

    logic r_prefer1;

    always_comb begin
        o_gnt0_c = i_req0 & (~i_req1 | ~r_prefer1);
        o_gnt1_c = i_req1 & (~i_req0 | r_prefer1);
    end

    // After granting M0 prefer M1, after granting M1 prefer M0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prefer1 <= 1'b1;
        end else if (i_accept) begin
            r_prefer1 <= o_gnt0_c;
        end
    end

endmodule

// File: rtl/axi_arbiter.sv
// Shares one single-beat AXI4-Lite slave port between IFU (M0, read-only) and LSU (M1, read/write).
module axi_arbiter
    import axi_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      m0_arvalid,
    input  logic [ADDR_WIDTH-1:0]     m0_araddr,
    output logic                      m0_arready,
    output logic                      m0_rvalid,
    output logic [DATA_WIDTH-1:0]     m0_rdata,
    output logic [1:0]                m0_rresp,
    input  logic                      m0_rready,
    input  logic                      m1_arvalid,
    input  logic [ADDR_WIDTH-1:0]     m1_araddr,
    output logic                      m1_arready,
    output logic                      m1_rvalid,
    output logic [DATA_WIDTH-1:0]     m1_rdata,
    output logic [1:0]                m1_rresp,
    input  logic                      m1_rready,
    input  logic                      m1_awvalid,
    input  logic [ADDR_WIDTH-1:0]     m1_awaddr,
    output logic                      m1_awready,
    input  logic                      m1_wvalid,
    input  logic [DATA_WIDTH-1:0]     m1_wdata,
    input  logic [DATA_WIDTH/8-1:0]   m1_wstrb,
    output logic                      m1_wready,
    output logic                      m1_bvalid,
    output logic [1:0]                m1_bresp,
    input  logic                      m1_bready,
    output logic                      s_arvalid,
    output logic [ADDR_WIDTH-1:0]     s_araddr,
    input  logic                      s_arready,
    input  logic                      s_rvalid,
    input  logic [DATA_WIDTH-1:0]     s_rdata,
    input  logic [1:0]                s_rresp,
    output logic                      s_rready,
    output logic                      s_awvalid,
    output logic [ADDR_WIDTH-1:0]     s_awaddr,
    input  logic                      s_awready,
    output logic                      s_wvalid,
    output logic [DATA_WIDTH-1:0]     s_wdata,
    output logic [DATA_WIDTH/8-1:0]   s_wstrb,
    input  logic                      s_wready,
    input  logic                      s_bvalid,
    input  logic [1:0]                s_bresp,
    output logic                      s_bready
);

    state_e r_state;
    state_e w_next;
    logic   w_req0;
    logic   w_req1;
    logic   w_accept;
    logic   w_gnt0;
    logic   w_gnt1;

    assign w_req0   = m0_arvalid;
    assign w_req1   = m1_arvalid | m1_awvalid;
    assign w_accept = (r_state == ST_IDLE) & (w_req0 | w_req1);

    axi_arbiter_rr_arb2 u_rr (
        .clk      (clk),
        .rst      (rst),
        .i_req0   (w_req0),
        .i_req1   (w_req1),
        .i_accept (w_accept),
        .o_gnt0_c (w_gnt0),
        .o_gnt1_c (w_gnt1)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state plus channel routing selected by the registered grant; IDLE forwards nothing.
    always_comb begin
        w_next     = r_state;
        m0_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = '0;
        m1_arready = 1'b0;
        m1_rvalid  = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = '0;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_bvalid  = 1'b0;
        m1_bresp   = '0;
        s_arvalid  = 1'b0;
        s_araddr   = '0;
        s_rready   = 1'b0;
        s_awvalid  = 1'b0;
        s_awaddr   = '0;
        s_wvalid   = 1'b0;
        s_wdata    = '0;
        s_wstrb    = '0;
        s_bready   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt0) begin
                    w_next = ST_RD0;
                end else if (w_gnt1) begin
                    w_next = m1_arvalid ? ST_RD1 : ST_WR1;
                end
            end
            ST_RD0: begin
                s_arvalid  = m0_arvalid;
                s_araddr   = m0_araddr;
                m0_arready = s_arready;
                m0_rvalid  = s_rvalid;
                m0_rdata   = s_rdata;
                m0_rresp   = s_rresp;
                s_rready   = m0_rready;
                if (s_rvalid & m0_rready) begin
                    w_next = ST_IDLE;
                end
            end
            ST_RD1: begin
                s_arvalid  = m1_arvalid;
                s_araddr   = m1_araddr;
                m1_arready = s_arready;
                m1_rvalid  = s_rvalid;
                m1_rdata   = s_rdata;
                m1_rresp   = s_rresp;
                s_rready   = m1_rready;
                if (s_rvalid & m1_rready) begin
                    w_next = ST_IDLE;
                end
            end
            ST_WR1: begin
                s_awvalid  = m1_awvalid;
                s_awaddr   = m1_awaddr;
                m1_awready = s_awready;
                s_wvalid   = m1_wvalid;
                s_wdata    = m1_wdata;
                s_wstrb    = m1_wstrb;
                m1_wready  = s_wready;
                m1_bvalid  = s_bvalid;
                m1_bresp   = s_bresp;
                s_bready   = m1_bready;
                if (s_bvalid & m1_bready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed bench for axi_arbiter: reactive slave, ownership model checked every cycle, literal pins per scenario.
module tb_axi_arbiter;
    import axi_arbiter_pkg::*;

    localparam int TMO = 60;

    logic        clk, rst;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic [31:0] m0_araddr, m0_rdata;
    logic [1:0]  m0_rresp;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic [31:0] m1_araddr, m1_rdata;
    logic [1:0]  m1_rresp;
    logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
    logic [31:0] m1_awaddr, m1_wdata;
    logic [3:0]  m1_wstrb;
    logic [1:0]  m1_bresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] s_araddr, s_rdata;
    logic [1:0]  s_rresp;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [31:0] s_awaddr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp;

    axi_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arready(m0_arready),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rready(m0_rready),
        .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arready(m1_arready),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rready(m1_rready),
        .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awready(m1_awready),
        .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wready(m1_wready),
        .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bready(m1_bready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void tmo(input string nm);
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL %s: timeout after %0d cycles, handshake expected", nm, TMO);
    endfunction

    // Output groups as seen by the compare process.
    logic [35:0]  g_m0;
    logic [40:0]  g_m1;
    logic [104:0] g_s;
    assign g_m0 = {m0_arready, m0_rvalid, m0_rdata, m0_rresp};
    assign g_m1 = {m1_arready, m1_rvalid, m1_rdata, m1_rresp, m1_awready, m1_wready, m1_bvalid, m1_bresp};
    assign g_s  = {s_arvalid, s_araddr, s_rready, s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready};

    // Ownership model: who holds the bus, and which master the round-robin favours next.
    typedef enum int {O_NONE, O_RD0, O_RD1, O_WR1} own_t;
    own_t own = O_NONE;
    bit   pref1 = 1'b1;
    initial forever begin
        bit r0, r1, pick1;
        @(posedge clk);
        if (!rst) begin
            own = O_NONE;
            pref1 = 1'b1;
        end else begin
            case (own)
                O_NONE: begin
                    r0 = m0_arvalid;
                    r1 = m1_arvalid || m1_awvalid;
                    if (r0 || r1) begin
                        pick1 = r1 && (!r0 || pref1);
                        own   = !pick1 ? O_RD0 : (m1_arvalid ? O_RD1 : O_WR1);
                        pref1 = !pick1;
                    end
                end
                O_RD0: if (s_rvalid && m0_rready) own = O_NONE;
                O_RD1: if (s_rvalid && m1_rready) own = O_NONE;
                O_WR1: if (s_bvalid && m1_bready) own = O_NONE;
                default: own = O_NONE;
            endcase
        end
    end

    initial begin
        logic [35:0]  e_m0;
        logic [40:0]  e_m1;
        logic [104:0] e_s;
        @(posedge clk);
        forever begin
            @(negedge clk);
            e_m0 = '0;
            e_m1 = '0;
            e_s  = '0;
            if (own == O_RD0) begin
                e_m0 = {s_arready, s_rvalid, s_rdata, s_rresp};
                e_s  = {m0_arvalid, m0_araddr, m0_rready, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0};
            end else if (own == O_RD1) begin
                e_m1 = {s_arready, s_rvalid, s_rdata, s_rresp, 1'b0, 1'b0, 1'b0, 2'b00};
                e_s  = {m1_arvalid, m1_araddr, m1_rready, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0};
            end else if (own == O_WR1) begin
                e_m1 = {1'b0, 1'b0, 32'h0, 2'b00, s_awready, s_wready, s_bvalid, s_bresp};
                e_s  = {1'b0, 32'h0, 1'b0, m1_awvalid, m1_awaddr, m1_wvalid, m1_wdata, m1_wstrb, m1_bready};
            end
            chk("m0_side", 128'(g_m0), 128'(e_m0));
            chk("m1_side", 128'(g_m1), 128'(e_m1));
            chk("slave_side", 128'(g_s), 128'(e_s));
            if (rst && own == O_NONE && (s_rvalid || s_bvalid)) begin
                chk("unsolicited_resp", 128'({s_rvalid, s_bvalid}), 128'(0));
            end
        end
    end

    // Reactive single-outstanding slave; read latency 3 cycles after the AR handshake.
    function automatic logic [31:0] rd_data_f(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h5A5A_5A5A);
    endfunction
    function automatic logic [1:0] resp_f(input logic [31:0] a);
        return (a[31:28] == 4'hE) ? RESP_SLVERR : RESP_OKAY;
    endfunction

    logic [31:0] ar_log[$];
    int          ar_cyc = 0, b_cyc = 0;
    logic [31:0] saw_awaddr, saw_wdata;
    logic [3:0]  saw_wstrb;
    initial begin
        bit kill, ar_hs, r_hs, aw_hs, w_hs, b_hs, rd_busy, aw_got, w_got;
        int rd_cnt;
        logic [31:0] rd_addr, wr_addr;
        rd_busy = 0; aw_got = 0; w_got = 0; rd_cnt = 0; rd_addr = '0; wr_addr = '0;
        s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = '0;
        forever begin
            @(negedge clk);
            kill  = !rst;
            ar_hs = s_arvalid && s_arready;
            r_hs  = s_rvalid && s_rready;
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            b_hs  = s_bvalid && s_bready;
            if (ar_hs) begin ar_log.push_back(s_araddr); ar_cyc = cyc; rd_addr = s_araddr; end
            if (aw_hs) begin saw_awaddr = s_awaddr; wr_addr = s_awaddr; end
            if (w_hs) begin saw_wdata = s_wdata; saw_wstrb = s_wstrb; end
            if (b_hs) b_cyc = cyc;
            @(posedge clk);
            #1;
            if (kill) begin
                rd_busy = 0; aw_got = 0; w_got = 0;
                s_rvalid = 0; s_rdata = '0; s_rresp = '0; s_bvalid = 0; s_bresp = '0;
            end else begin
                if (ar_hs) begin
                    rd_busy = 1;
                    rd_cnt  = 3;
                end else if (r_hs) begin
                    rd_busy = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0;
                end else if (rd_busy && !s_rvalid) begin
                    if (rd_cnt == 1) begin
                        s_rvalid = 1; s_rdata = rd_data_f(rd_addr); s_rresp = resp_f(rd_addr);
                    end else begin
                        rd_cnt = rd_cnt - 1;
                    end
                end
                if (aw_hs) aw_got = 1;
                if (w_hs) w_got = 1;
                if (b_hs) begin
                    s_bvalid = 0; s_bresp = '0; aw_got = 0; w_got = 0;
                end else if (aw_got && w_got && !s_bvalid) begin
                    s_bvalid = 1; s_bresp = resp_f(wr_addr);
                end
            end
            s_arready = !kill && !rd_busy;
            s_awready = !kill && !aw_got;
            s_wready  = !kill && !w_got;
        end
    end

    int m0_req_cyc = 0;

    task automatic m0_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        m0_arvalid = 1; m0_araddr = a; m0_req_cyc = cyc;
        n = 0;
        forever begin
            @(negedge clk);
            if (m0_arready) break;
            n++;
            if (n > TMO) begin tmo("m0_ar"); break; end
        end
        @(posedge clk); #1;
        m0_arvalid = 0; m0_araddr = '0; m0_rready = 1;
        n = 0;
        forever begin
            @(negedge clk);
            if (m0_rvalid) break;
            n++;
            if (n > TMO) begin tmo("m0_r"); break; end
        end
        d = m0_rdata; r = m0_rresp;
        @(posedge clk); #1;
        m0_rready = 0;
    endtask

    task automatic m1_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        m1_arvalid = 1; m1_araddr = a;
        n = 0;
        forever begin
            @(negedge clk);
            if (m1_arready) break;
            n++;
            if (n > TMO) begin tmo("m1_ar"); break; end
        end
        @(posedge clk); #1;
        m1_arvalid = 0; m1_araddr = '0; m1_rready = 1;
        n = 0;
        forever begin
            @(negedge clk);
            if (m1_rvalid) break;
            n++;
            if (n > TMO) begin tmo("m1_r"); break; end
        end
        d = m1_rdata; r = m1_rresp;
        @(posedge clk); #1;
        m1_rready = 0;
    endtask

    task automatic m1_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input bit aw_first, input bit hold_b, output logic [1:0] br);
        int n;
        bit aw_done, w_done, a_h, w_h;
        aw_done = 0; w_done = 0; n = 0;
        m1_awvalid = 1; m1_awaddr = a;
        if (!aw_first) begin m1_wvalid = 1; m1_wdata = d; m1_wstrb = s; end
        while (!(aw_done && w_done)) begin
            @(negedge clk);
            a_h = m1_awvalid && m1_awready;
            w_h = m1_wvalid && m1_wready;
            n++;
            if (n > TMO) begin tmo("m1_aw_w"); break; end
            @(posedge clk); #1;
            if (a_h) begin
                aw_done = 1; m1_awvalid = 0; m1_awaddr = '0;
                if (aw_first) begin m1_wvalid = 1; m1_wdata = d; m1_wstrb = s; end
            end
            if (w_h) begin w_done = 1; m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0; end
        end
        m1_bready = !hold_b;
        n = 0;
        forever begin
            @(negedge clk);
            if (m1_bvalid) break;
            n++;
            if (n > TMO) begin tmo("m1_b"); break; end
        end
        br = m1_bresp;
        if (!hold_b) begin
            @(posedge clk); #1;
            m1_bready = 0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d0, d1;
        logic [1:0]  r0, r1, br;
        int base;
        rst = 0;
        m0_arvalid = 0; m0_araddr = '0; m0_rready = 0;
        m1_arvalid = 0; m1_araddr = '0; m1_rready = 0;
        m1_awvalid = 0; m1_awaddr = '0; m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_bready = 0;

        // 1: reset with every master valid high, then first grant goes to M1.
        @(posedge clk); #1;
        m0_arvalid = 1; m0_araddr = 32'h1000_0040;
        m1_arvalid = 1; m1_araddr = 32'h2000_0040;
        m1_awvalid = 1; m1_awaddr = 32'h2000_0080; m1_wvalid = 1; m1_wdata = 32'h1234_5678; m1_wstrb = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_m0_zero", 128'(g_m0), 128'(0));
        chk("reset_m1_zero", 128'(g_m1), 128'(0));
        chk("reset_s_zero", 128'(g_s), 128'(0));
        @(posedge clk); #1;
        rst = 1;
        m1_awvalid = 0; m1_awaddr = '0; m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0;
        fork
            m0_read(32'h1000_0040, d0, r0);
            m1_read(32'h2000_0040, d1, r1);
        join
        chk("first_grant_m1", 128'(ar_log[0]), 128'(32'h2000_0040));
        chk("second_grant_m0", 128'(ar_log[1]), 128'(32'h1000_0040));
        chk("t1_m1_rdata", 128'(d1), 128'(32'h2000_0040 ^ 32'h5A5A_5A5A));

        // 2: M0 alone; slave sees AR one cycle after the request.
        @(posedge clk); #1;
        m0_read(32'h8000_0000, d0, r0);
        chk("t2_ar_latency", 128'(ar_cyc - m0_req_cyc), 128'(1));
        chk("t2_m0_rdata", 128'(d0), 128'(32'h0000_0413));
        chk("t2_m0_rresp", 128'(r0), 128'(RESP_OKAY));
        @(negedge clk);
        chk("t2_back_idle", 128'(dut.r_state), 128'(ST_IDLE));

        // 3: both masters keep requesting; grants alternate M1, M0, ...
        @(posedge clk); #1;
        base = ar_log.size();
        fork
            begin
                logic [31:0] da; logic [1:0] ra;
                for (int i = 0; i < 3; i++) begin
                    m0_read(32'h1000_0100 + 32'(i * 4), da, ra);
                    chk("t3_m0_rdata", 128'(da), 128'((32'h1000_0100 + 32'(i * 4)) ^ 32'h5A5A_5A5A));
                end
            end
            begin
                logic [31:0] db; logic [1:0] rb;
                for (int j = 0; j < 3; j++) begin
                    m1_read(32'h2000_0100 + 32'(j * 4), db, rb);
                    chk("t3_m1_rdata", 128'(db), 128'((32'h2000_0100 + 32'(j * 4)) ^ 32'h5A5A_5A5A));
                end
            end
        join
        chk("t3_grant_count", 128'(ar_log.size() - base), 128'(6));
        for (int k = 0; k < 6; k++) begin
            chk("t3_alternation", 128'(ar_log[base + k][31:28]), 128'((k % 2 == 0) ? 4'h2 : 4'h1));
        end

        // 4: M1 write with AW before W; an M0 read arriving meanwhile waits for the B handshake.
        @(posedge clk); #1;
        fork
            m1_write(32'h8000_0100, 32'hDEAD_BEEF, 4'b0011, 1'b1, 1'b0, br);
            begin
                @(posedge clk); #1;
                m0_read(32'h1000_0200, d0, r0);
            end
        join
        chk("t4_awaddr", 128'(saw_awaddr), 128'(32'h8000_0100));
        chk("t4_wdata", 128'(saw_wdata), 128'(32'hDEAD_BEEF));
        chk("t4_wstrb", 128'(saw_wstrb), 128'(4'b0011));
        chk("t4_bresp", 128'(br), 128'(RESP_OKAY));
        chk("t4_m0_after_b", 128'(ar_cyc - b_cyc), 128'(2));
        chk("t4_m0_rdata", 128'(d0), 128'(32'h1000_0200 ^ 32'h5A5A_5A5A));

        // 5: SLVERR to M1 is forwarded and still releases the bus to a waiting M0.
        @(posedge clk); #1;
        base = ar_log.size();
        fork
            m1_read(32'hE000_0010, d1, r1);
            begin
                @(posedge clk); #1;
                m0_read(32'h1000_0300, d0, r0);
            end
        join
        chk("t5_m1_rresp", 128'(r1), 128'(RESP_SLVERR));
        chk("t5_m1_rdata", 128'(d1), 128'(32'hE000_0010 ^ 32'h5A5A_5A5A));
        chk("t5_order_m1", 128'(ar_log[base]), 128'(32'hE000_0010));
        chk("t5_order_m0", 128'(ar_log[base + 1]), 128'(32'h1000_0300));
        chk("t5_m0_rresp", 128'(r0), 128'(RESP_OKAY));

        // 6: reset while WR1 holds a pending B response; bus returns to idle and works again.
        @(posedge clk); #1;
        m1_write(32'h8000_0200, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b1, br);
        chk("t6_b_pending", 128'({m1_bvalid, dut.r_state}), 128'({1'b1, ST_WR1}));
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        rst = 1;
        m1_bready = 0;
        @(negedge clk);
        chk("t6_state_idle", 128'(dut.r_state), 128'(ST_IDLE));
        chk("t6_m0_zero", 128'(g_m0), 128'(0));
        chk("t6_m1_zero", 128'(g_m1), 128'(0));
        chk("t6_s_zero", 128'(g_s), 128'(0));
        @(posedge clk); #1;
        m0_read(32'h8000_0000, d0, r0);
        chk("t6_m0_rdata", 128'(d0), 128'(32'h0000_0413));
        chk("t6_m0_rresp", 128'(r0), 128'(RESP_OKAY));

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
